time_keeper: RTL and testbench
==============================

Name: time_keeper

Overview:
- Timebase for the ammeter clock; sits directly upstream of the second/minute/hour PWM meter drivers.
- Divides the system clock into a 1 Hz tick (parameterisable).
- Keeps registered seconds, minutes and hours counters. `sec_o` feeds the seconds meter's 8-bit `time_data` input.
- Accepts a whole-time load and per-field increment strobes for setting the clock.

Parameters:
- SYSCLKHZ, 5000_0000, system clock frequency in Hz.
- TICK_HZ, 1, tick rate in Hz. DIV = SYSCLKHZ/TICK_HZ; DIV must be >= 2.
- HOUR_MODE, 24, hour range: 24 gives 0..23, 12 gives 0..11. Other values are illegal; flag them with an elaboration error.

Ports:
- clk  in  1  system clock
- Rst_n  in  1  asynchronous active-low reset
- En  in  1  run enable; when low, the prescaler holds and no ticks occur
- ld_stb  in  1  single-cycle load request
- ld_sec  in  8  load value, seconds
- ld_min  in  8  load value, minutes
- ld_hour  in  8  load value, hours
- inc_stb  in  1  single-cycle field increment request
- inc_sel  in  2  increment field: 0 = sec, 1 = min, 2 = hour, 3 = ignored
- sec_o  out  8  seconds 0..59, registered
- min_o  out  8  minutes 0..59, registered
- hour_o  out  8  hours 0..HOUR_MODE-1, registered
- tick_o  out  1  one-cycle pulse in the cycle the counters show a tick update
- ld_err_o  out  1  one-cycle pulse when a load is rejected

Behaviour:
- Reset (Rst_n low, async): prescaler = 0, pend = 0, all of sec_o/min_o/hour_o = 0, tick_o = 0, ld_err_o = 0.
- Prescaler:
  - Counts 0..DIV-1 while En = 1 and holds while En = 0.
  - tick_int is asserted when count == DIV-1 and En = 1; the counter then wraps to 0.
  - The width is derived from DIV ($clog2).
- Tick application:
  - sec+1. At 59 it wraps to 0 and carries min+1.
  - min at 59 wraps to 0 and carries hour+1.
  - hour at HOUR_MODE-1 wraps to 0.
  - All fields update in the same cycle.
- Latency: counters change on the clock edge after tick_int. tick_o is registered and is high exactly while the new values are first visible.
- Priority per cycle: load > increment > tick.
- Load (ld_stb = 1):
  - Valid only if ld_sec <= 59, ld_min <= 59 and ld_hour <= HOUR_MODE-1.
  - Valid load: all three fields are written next edge, the prescaler is cleared to 0, pend is cleared, and any coincident tick_int or inc_stb is discarded; tick_o = 0.
  - Invalid load: no field changes, ld_err_o pulses next cycle, and the cycle is then processed as if ld_stb = 0 (increment/tick still apply).
- Increment (inc_stb = 1, no valid load):
  - The selected field is +1 with wrap at its own limit, with no carry into higher fields.
  - inc_sel = 3 is a no-op.
  - The prescaler is unaffected.
- Simultaneous increment and tick_int:
  - The increment is applied and the tick is held in a one-bit pend register.
  - pend is applied on the next cycle that has no load and no increment.
  - tick_o is asserted when pend is applied.
  - If tick_int arrives while pend = 1 and is blocked again, only one tick is kept. This is unreachable for DIV >= 2 with single-cycle strobes and must be covered by an assertion.
- Pend and En: a pending tick is applied even if En has dropped.
- Ordinary tick: when pend = 0 and no load/increment, tick_int is applied directly.
- Reset mid-operation: all state clears immediately, including pend and the prescaler; no tick_o is emitted on reset release.
- Output ranges: outputs never leave their ranges. Formal/assertion checks: sec_o <= 59, min_o <= 59, hour_o < HOUR_MODE.
- Implementation: one always_ff for prescaler/pend/fields; combinational next-state with explicit priority mux.

Test Plan (SYSCLKHZ=10, TICK_HZ=1, DIV=10, HOUR_MODE=24):
1. Release reset with En = 1 for 25 cycles -> tick_o pulses on cycles 10 and 20; sec_o 0 -> 1 -> 2; min_o = hour_o = 0.
2. Load 23:59:58 with ld_stb, run two ticks -> 23:59:59, then 00:00:00 with tick_o high in the cycle hour_o wraps to 0.
3. Load ld_sec = 60 -> ld_err_o pulses once, and the time and prescaler continue unchanged. Then load 12:34:56 in the same cycle as tick_int -> 12:34:56 with no tick_o, and the next tick arrives a full DIV cycles later.
4. inc_sel = 0 with sec = 59, min = 7 -> sec = 0, min stays 7. inc_sel = 3 -> no change. inc_sel = 2 with hour = 23 -> hour = 0.
5. inc_stb (sel = 1) coincident with tick_int -> min+1 that edge; sec+1 with tick_o exactly one cycle later. A back-to-back inc_stb on that next cycle defers the tick one further cycle.
6. En low for 30 cycles mid-count (prescaler = 4) -> no ticks. On re-enable, the next tick arrives after 6 cycles. Assert Rst_n mid-count -> all outputs 0 immediately and the first tick comes 10 cycles after release.
7. Repeat scenario 2 with HOUR_MODE = 12: load 11:59:59 and tick -> 00:00:00.

Source files
------------

// File: rtl/time_keeper.sv
// time_keeper: timebase for the ammeter clock.
// Divides the system clock down to a tick and keeps seconds/minutes/hours
// counters for the PWM meter drivers. A whole-time load and per-field
// increments set the clock. Each cycle the priority is load > increment > tick.
// A tick that collides with an increment is held for one cycle, not lost.
module time_keeper #(
  parameter int SYSCLKHZ  = 50_000_000,
  parameter int TICK_HZ   = 1,
  parameter int HOUR_MODE = 24
) (
  input  logic       clk,
  input  logic       Rst_n,
  input  logic       En,
  input  logic       ld_stb,
  input  logic [7:0] ld_sec,
  input  logic [7:0] ld_min,
  input  logic [7:0] ld_hour,
  input  logic       inc_stb,
  input  logic [1:0] inc_sel,
  output logic [7:0] sec_o,
  output logic [7:0] min_o,
  output logic [7:0] hour_o,
  output logic       tick_o,
  output logic       ld_err_o
);

  localparam int              DIV       = SYSCLKHZ / TICK_HZ;
  localparam int              CW        = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0]   PRESC_MAX = CW'(DIV - 1);
  localparam logic [7:0]      SEC_MAX   = 8'd59;
  localparam logic [7:0]      HOUR_MAX  = 8'(HOUR_MODE - 1);

  // Reject parameterisations the counters cannot honour.
  if (HOUR_MODE != 24 && HOUR_MODE != 12) begin : g_bad_hour_mode
    $error("time_keeper: HOUR_MODE must be 12 or 24");
  end
  if (DIV < 2) begin : g_bad_div
    $error("time_keeper: SYSCLKHZ/TICK_HZ must be at least 2");
  end

  logic [CW-1:0] presc_q, presc_d;
  logic          pend_q, pend_d;
  logic [7:0]    sec_q, sec_d;
  logic [7:0]    min_q, min_d;
  logic [7:0]    hour_q, hour_d;
  logic          tick_q, tick_d;
  logic          ld_err_q, ld_err_d;

  logic tick_int;
  logic ld_ok;
  logic inc_act;

  // Increment with wrap to zero once the field's limit is reached.
  function automatic logic [7:0] wrap_inc(input logic [7:0] v, input logic [7:0] max);
    return (v >= max) ? 8'd0 : v + 8'd1;
  endfunction

  // Next-state: prescaler, then the load > increment > tick priority mux.
  always_comb begin
    // NOTE: every next-state signal gets a default before any branch, so no
    // path can leave one unassigned and infer a latch.
    presc_d  = presc_q;
    pend_d   = pend_q;
    sec_d    = sec_q;
    min_d    = min_q;
    hour_d   = hour_q;
    tick_d   = 1'b0;

    tick_int = En && (presc_q == PRESC_MAX);
    ld_ok    = ld_stb && (ld_sec <= SEC_MAX) && (ld_min <= SEC_MAX) && (ld_hour <= HOUR_MAX);
    inc_act  = inc_stb && (inc_sel != 2'd3);
    ld_err_d = ld_stb && !ld_ok;

    if (En) begin
      presc_d = tick_int ? '0 : presc_q + 1'b1;
    end

    if (ld_ok) begin
      // A valid load restarts the second: prescaler and pending tick are dropped.
      sec_d   = ld_sec;
      min_d   = ld_min;
      hour_d  = ld_hour;
      presc_d = '0;
      pend_d  = 1'b0;
    end else if (inc_act) begin
      // Setting a field never carries; a colliding tick waits in pend.
      case (inc_sel)
        2'd0:    sec_d  = wrap_inc(sec_q, SEC_MAX);
        2'd1:    min_d  = wrap_inc(min_q, SEC_MAX);
        2'd2:    hour_d = wrap_inc(hour_q, HOUR_MAX);
        default: ;
      endcase
      pend_d = pend_q | tick_int;
    end else if (pend_q || tick_int) begin
      // One tick: seconds, with carries rippling into minutes and hours.
      sec_d = wrap_inc(sec_q, SEC_MAX);
      if (sec_q == SEC_MAX) begin
        min_d = wrap_inc(min_q, SEC_MAX);
        if (min_q == SEC_MAX) begin
          hour_d = wrap_inc(hour_q, HOUR_MAX);
        end
      end
      pend_d = 1'b0;
      tick_d = 1'b1;
    end
  end

  // State registers: prescaler, pending tick, time fields and output pulses.
  always_ff @(posedge clk or negedge Rst_n) begin
    if (!Rst_n) begin
      presc_q  <= '0;
      pend_q   <= 1'b0;
      sec_q    <= 8'd0;
      min_q    <= 8'd0;
      hour_q   <= 8'd0;
      tick_q   <= 1'b0;
      ld_err_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      presc_q  <= presc_d;
      pend_q   <= pend_d;
      sec_q    <= sec_d;
      min_q    <= min_d;
      hour_q   <= hour_d;
      tick_q   <= tick_d;
      ld_err_q <= ld_err_d;
    end
  end

  assign sec_o    = sec_q;
  assign min_o    = min_q;
  assign hour_o   = hour_q;
  assign tick_o   = tick_q;
  assign ld_err_o = ld_err_q;

  // A second tick must never arrive while one is still pending.
  a_no_double_pend: assert property (@(posedge clk) disable iff (!Rst_n) !(pend_q && tick_int));
  a_sec_range:      assert property (@(posedge clk) disable iff (!Rst_n) sec_q <= SEC_MAX);
  a_min_range:      assert property (@(posedge clk) disable iff (!Rst_n) min_q <= SEC_MAX);
  a_hour_range:     assert property (@(posedge clk) disable iff (!Rst_n) hour_q <= HOUR_MAX);

endmodule

// File: tb/tb_time_keeper.sv
// Bench for time_keeper: a 24-hour and a 12-hour instance share the same
// stimulus. A total-seconds model per instance is compared every cycle,
// and directed scenarios add hand-computed expectations.
module tb_time_keeper;

  localparam int DIV = 10;

  logic       clk = 1'b0;
  logic       rst_n, en, ld_stb, inc_stb;
  logic [7:0] ld_sec, ld_min, ld_hour;
  logic [1:0] inc_sel;

  logic [7:0] sec_a, min_a, hour_a, sec_b, min_b, hour_b;
  logic       tick_a, err_a, tick_b, err_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  time_keeper #(.SYSCLKHZ(10), .TICK_HZ(1), .HOUR_MODE(24)) dut24 (
    .clk(clk), .Rst_n(rst_n), .En(en), .ld_stb(ld_stb), .ld_sec(ld_sec),
    .ld_min(ld_min), .ld_hour(ld_hour), .inc_stb(inc_stb), .inc_sel(inc_sel),
    .sec_o(sec_a), .min_o(min_a), .hour_o(hour_a), .tick_o(tick_a), .ld_err_o(err_a)
  );

  time_keeper #(.SYSCLKHZ(10), .TICK_HZ(1), .HOUR_MODE(12)) dut12 (
    .clk(clk), .Rst_n(rst_n), .En(en), .ld_stb(ld_stb), .ld_sec(ld_sec),
    .ld_min(ld_min), .ld_hour(ld_hour), .inc_stb(inc_stb), .inc_sel(inc_sel),
    .sec_o(sec_b), .min_o(min_b), .hour_o(hour_b), .tick_o(tick_b), .ld_err_o(err_b)
  );

  // Model state: time of day as total seconds, cycles since the last tick.
  typedef struct {
    int t;
    int pc;
    bit pend;
    bit tk;
    bit er;
  } mstate_t;

  mstate_t mdl [2];

  function automatic int hm_of(input int m);
    return (m == 0) ? 24 : 12;
  endfunction

  function automatic mstate_t step(input mstate_t s, input int hm);
    mstate_t n;
    int  sec, mn, hr;
    bit  ti, valid;
    n     = s;
    n.tk  = 1'b0;
    sec   = s.t % 60;
    mn    = (s.t / 60) % 60;
    hr    = s.t / 3600;
    ti    = en && (s.pc == DIV - 1);
    valid = ld_stb && (ld_sec <= 59) && (ld_min <= 59) && (int'(ld_hour) < hm);
    n.er  = ld_stb && !valid;
    n.pc  = en ? (ti ? 0 : s.pc + 1) : s.pc;
    if (valid) begin
      n.t    = int'(ld_hour) * 3600 + int'(ld_min) * 60 + int'(ld_sec);
      n.pc   = 0;
      n.pend = 1'b0;
    end else if (inc_stb && inc_sel != 2'd3) begin
      if (inc_sel == 2'd0) n.t = s.t - sec + (sec + 1) % 60;
      if (inc_sel == 2'd1) n.t = s.t - mn * 60 + ((mn + 1) % 60) * 60;
      if (inc_sel == 2'd2) n.t = s.t - hr * 3600 + ((hr + 1) % hm) * 3600;
      n.pend = s.pend | ti;
    end else if (s.pend || ti) begin
      n.t    = (s.t + 1) % (hm * 3600);
      n.pend = 1'b0;
      n.tk   = 1'b1;
    end
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int m = 0; m < 2; m++) mdl[m] <= '{default: 0};
    end else begin
      for (int m = 0; m < 2; m++) mdl[m] <= step(mdl[m], hm_of(m));
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of both instances against their models.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      check("m24 sec",  sec_a,  32'(mdl[0].t % 60));
      check("m24 min",  min_a,  32'((mdl[0].t / 60) % 60));
      check("m24 hour", hour_a, 32'(mdl[0].t / 3600));
      check("m24 tick", tick_a, 32'(mdl[0].tk));
      check("m24 err",  err_a,  32'(mdl[0].er));
      check("m12 sec",  sec_b,  32'(mdl[1].t % 60));
      check("m12 min",  min_b,  32'((mdl[1].t / 60) % 60));
      check("m12 hour", hour_b, 32'(mdl[1].t / 3600));
      check("m12 tick", tick_b, 32'(mdl[1].tk));
      check("m12 err",  err_b,  32'(mdl[1].er));
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input int h, input int m, input int s);
    ld_hour = 8'(h);
    ld_min  = 8'(m);
    ld_sec  = 8'(s);
    ld_stb  = 1'b1;
    cycle();
    ld_stb  = 1'b0;
  endtask

  task automatic do_inc(input int sel);
    inc_sel = 2'(sel);
    inc_stb = 1'b1;
    cycle();
    inc_stb = 1'b0;
  endtask

  task automatic wait_pc(input int target);
    int n = 0;
    while (mdl[0].pc != target && n < 40) begin
      cycle();
      n++;
    end
    if (mdl[0].pc != target) begin
      checks++;
      errors++;
      $display("FAIL wait_pc: prescaler %0d, required %0d", mdl[0].pc, target);
    end
  endtask

  task automatic wait_tick(output int n);
    n = 0;
    do begin
      cycle();
      n++;
    end while (!tick_a && n < 40);
  endtask

  task automatic check_time24(input string name, input int h, input int m, input int s);
    check({name, " hour"}, hour_a, 32'(h));
    check({name, " min"},  min_a,  32'(m));
    check({name, " sec"},  sec_a,  32'(s));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int first, second, nt, n;
    rst_n = 1'b0; en = 1'b1; ld_stb = 1'b0; inc_stb = 1'b0; inc_sel = 2'd0;
    ld_sec = 8'd0; ld_min = 8'd0; ld_hour = 8'd0;
    repeat (3) cycle();
    check_time24("reset", 0, 0, 0);
    check("reset tick", tick_a, 0);
    check("reset err", err_a, 0);

    // 1: free run after reset, ticks on cycles 10 and 20.
    rst_n = 1'b1;
    first = 0; second = 0; nt = 0;
    for (int i = 1; i <= 25; i++) begin
      cycle();
      if (tick_a) begin
        nt++;
        if (nt == 1) first = i;
        else if (nt == 2) second = i;
      end
    end
    check("run tick count", nt, 2);
    check("run first tick", first, 10);
    check("run second tick", second, 20);
    check_time24("run", 0, 0, 2);

    // 2: load 23:59:58 and roll over midnight.
    do_load(23, 59, 58);
    check_time24("load", 23, 59, 58);
    check("load tick", tick_a, 0);
    wait_tick(n);
    check("roll1 latency", n, 10);
    check_time24("roll1", 23, 59, 59);
    wait_tick(n);
    check("roll2 latency", n, 10);
    check_time24("roll2", 0, 0, 0);
    check("roll2 tick", tick_a, 1);

    // 3: rejected load, then a load that swallows a tick.
    do_load(0, 0, 60);
    check("bad load err", err_a, 1);
    check_time24("bad load", 0, 0, 0);
    cycle();
    check("bad load err gone", err_a, 0);
    wait_tick(n);
    check("presc kept", n, 8);
    check_time24("after bad", 0, 0, 1);
    wait_pc(DIV - 1);
    do_load(12, 34, 56);
    check_time24("load on tick", 12, 34, 56);
    check("load on tick tick", tick_a, 0);
    wait_tick(n);
    check("tick after load", n, 10);

    // 4: field increments, no carries.
    do_load(0, 7, 59);
    do_inc(0);
    check_time24("inc sec wrap", 0, 7, 0);
    do_inc(3);
    check_time24("inc noop", 0, 7, 0);
    do_load(23, 0, 0);
    do_inc(2);
    check_time24("inc hour wrap", 0, 0, 0);

    // 5: increment coincident with a tick defers it one cycle.
    wait_pc(DIV - 1);
    do_inc(1);
    check_time24("inc on tick", 0, 1, 0);
    check("inc on tick tick", tick_a, 0);
    cycle();
    check_time24("pend applied", 0, 1, 1);
    check("pend tick", tick_a, 1);
    wait_pc(DIV - 1);
    inc_sel = 2'd1;
    inc_stb = 1'b1;
    cycle();
    cycle();
    inc_stb = 1'b0;
    check_time24("b2b inc", 0, 3, 1);
    check("b2b inc tick", tick_a, 0);
    cycle();
    check_time24("b2b pend", 0, 3, 2);
    check("b2b pend tick", tick_a, 1);

    // 6: pend survives En low, prescaler hold, mid-count reset.
    wait_pc(DIV - 1);
    do_inc(0);
    en = 1'b0;
    cycle();
    check_time24("pend en low", 0, 3, 4);
    check("pend en low tick", tick_a, 1);
    en = 1'b1;
    wait_pc(4);
    en = 1'b0;
    nt = 0;
    for (int i = 0; i < 30; i++) begin
      cycle();
      if (tick_a) nt++;
    end
    check("hold no ticks", nt, 0);
    check("hold sec", sec_a, 4);
    en = 1'b1;
    wait_tick(n);
    check("resume latency", n, 6);
    check("resume sec", sec_a, 5);
    repeat (3) cycle();
    #2 rst_n = 1'b0;
    #1;
    check_time24("async reset", 0, 0, 0);
    check("async reset m12 sec", sec_b, 0);
    repeat (2) cycle();
    rst_n = 1'b1;
    wait_tick(n);
    check("post reset latency", n, 10);
    check("post reset sec", sec_a, 1);

    // 7: 12-hour rollover.
    do_load(11, 59, 59);
    check("m12 load hour", hour_b, 11);
    wait_tick(n);
    check("m12 roll latency", n, 10);
    check("m12 roll hour", hour_b, 0);
    check("m12 roll min", min_b, 0);
    check("m12 roll sec", sec_b, 0);
    check("m12 roll tick", tick_b, 1);
    check_time24("m24 noon", 12, 0, 0);

    repeat (2) cycle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
